// File: rtl/tcm_rib_arbiter_pkg.sv
// Shared constants and types for the TCM RIB arbiter and its FIFOs.
package tcm_rib_arbiter_pkg;

  // RIB bus widths
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Master IDs as carried in the in-order ID FIFO
  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  // Arbitration mode encodings
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // One RIB request as presented to the slave
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wrcs;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] wdata;
  } rib_req_t;

endpackage

// File: rtl/rib_sync_fifo.sv
// Small synchronous FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop of an empty FIFO
// is ignored.
module rib_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage; contents are only observed while non-empty, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tcm_rib_arbiter.sv
// Two-master to one-slave RIB arbiter in front of a TCM controller.
// Handshake: a request transfers in the cycle where req and gnt are both 1
// (gnt is combinational, no added latency; a waiting master holds req and
// its fields stable). A response transfers in the cycle where rsp and rdy
// are both 1; the slave side is always ready (o_s_rdy = 1).
module tcm_rib_arbiter
  import tcm_rib_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int OUTST    = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic              i_m0_wrcs,
  input  logic [MASK_W-1:0] i_m0_mask,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m0_req,
  output logic              o_m0_gnt,
  output logic              o_m0_rsp,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m0_rdy,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic              i_m1_wrcs,
  input  logic [MASK_W-1:0] i_m1_mask,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_req,
  output logic              o_m1_gnt,
  output logic              o_m1_rsp,
  output logic [DATA_W-1:0] o_m1_rdata,
  input  logic              i_m1_rdy,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic              o_s_wrcs,
  output logic [MASK_W-1:0] o_s_mask,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic              o_s_req,
  input  logic              i_s_gnt,
  input  logic              i_s_rsp,
  input  logic [DATA_W-1:0] i_s_rdata,
  output logic              o_s_rdy
);

  localparam int CW = $clog2(OUTST+1);

  rib_req_t    req_m0, req_m1, req_s;
  logic        cand0, cand1, win0, win1;
  logic        elig0, elig1;
  logic        last_m1;
  logic [CW-1:0] pend0, pend1, id_count;
  logic [CW-1:0] buf_cnt0, buf_cnt1;
  logic [CW:0]   sum0, sum1;
  logic        id_push, id_pop, id_full, id_empty, id_head;
  logic        rsp0, rsp1, bypass0, bypass1;
  logic        buf_push0, buf_push1, buf_pop0, buf_pop1;
  logic        buf_full0, buf_full1, buf_empty0, buf_empty1;
  logic [DATA_W-1:0] buf_dout0, buf_dout1;

  assign req_m0 = '{addr: i_m0_addr, wrcs: i_m0_wrcs, mask: i_m0_mask, wdata: i_m0_wdata};
  assign req_m1 = '{addr: i_m1_addr, wrcs: i_m1_wrcs, mask: i_m1_mask, wdata: i_m1_wdata};

  // A master may issue only while its in-flight plus buffered responses fit
  // in its response buffer, so a buffered response can never overflow.
  assign pend0 = id_count - pend1;
  assign sum0  = {1'b0, pend0} + {1'b0, buf_cnt0};
  assign sum1  = {1'b0, pend1} + {1'b0, buf_cnt1};
  assign elig0 = (sum0 < (CW+1)'(OUTST)) & ~id_full;
  assign elig1 = (sum1 < (CW+1)'(OUTST)) & ~id_full;
  assign cand0 = i_m0_req & elig0;
  assign cand1 = i_m1_req & elig1;

  // Winner selection: fixed priority to M0, or alternate on contention
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (ARB_MODE == ARB_FIXED) begin
      win0 = cand0;
      win1 = cand1 & ~cand0;
    end else if (cand0 && cand1) begin
      win0 = last_m1;
      win1 = ~last_m1;
    end else begin
      win0 = cand0;
      win1 = cand1;
    end
  end

  // Slave request mux; fields follow M0 when nobody wins
  assign req_s     = win1 ? req_m1 : req_m0;
  assign o_s_req   = win0 | win1;
  assign o_s_addr  = req_s.addr;
  assign o_s_wrcs  = req_s.wrcs;
  assign o_s_mask  = req_s.mask;
  assign o_s_wdata = req_s.wdata;
  assign o_s_rdy   = 1'b1;

  assign o_m0_gnt = win0 & i_s_gnt;
  assign o_m1_gnt = win1 & i_s_gnt;
  assign id_push  = o_s_req & i_s_gnt;

  // Responses come back in issue order; the FIFO head names the owner.
  // A response with nothing outstanding (pre-reset leftover) is dropped.
  assign id_pop    = i_s_rsp & ~id_empty;
  assign rsp0      = id_pop & (id_head == MID_M0);
  assign rsp1      = id_pop & (id_head == MID_M1);
  assign bypass0   = rsp0 & buf_empty0 & i_m0_rdy;
  assign bypass1   = rsp1 & buf_empty1 & i_m1_rdy;
  assign buf_push0 = rsp0 & ~bypass0;
  assign buf_push1 = rsp1 & ~bypass1;
  assign buf_pop0  = ~buf_empty0 & i_m0_rdy;
  assign buf_pop1  = ~buf_empty1 & i_m1_rdy;

  // Buffered data always goes first so a fresh response never overtakes it
  assign o_m0_rsp   = ~buf_empty0 | bypass0;
  assign o_m1_rsp   = ~buf_empty1 | bypass1;
  assign o_m0_rdata = ~buf_empty0 ? buf_dout0 : (bypass0 ? i_s_rdata : '0);
  assign o_m1_rdata = ~buf_empty1 ? buf_dout1 : (bypass1 ? i_s_rdata : '0);

  // Round-robin pointer and M1 in-flight count (M0 count is the remainder)
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_m1 <= 1'b1;
      pend1   <= '0;
    end else begin
      if (id_push) last_m1 <= win1;
      case ({id_push & win1, rsp1})
        2'b10:   pend1 <= pend1 + 1'b1;
        2'b01:   pend1 <= pend1 - 1'b1;
        default: ;
      endcase
    end
  end

  rib_sync_fifo #(.WIDTH(1), .DEPTH(OUTST)) u_id_fifo (
    .clk(i_clk), .rst_n(i_rstn),
    .push(id_push), .din(win1), .pop(id_pop), .dout(id_head),
    .full(id_full), .empty(id_empty), .count(id_count)
  );

  rib_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUTST)) u_rsp_buf0 (
    .clk(i_clk), .rst_n(i_rstn),
    .push(buf_push0), .din(i_s_rdata), .pop(buf_pop0), .dout(buf_dout0),
    .full(buf_full0), .empty(buf_empty0), .count(buf_cnt0)
  );

  rib_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUTST)) u_rsp_buf1 (
    .clk(i_clk), .rst_n(i_rstn),
    .push(buf_push1), .din(i_s_rdata), .pop(buf_pop1), .dout(buf_dout1),
    .full(buf_full1), .empty(buf_empty1), .count(buf_cnt1)
  );

  // A slave response with no outstanding ID is flagged and dropped
  stale_rsp: assert property (@(posedge i_clk) disable iff (!i_rstn) !(i_s_rsp && id_empty))
    else $warning("tcm_rib_arbiter: slave response with no outstanding ID dropped");

  // Eligibility keeps the response buffers from overflowing
  no_ovf0: assert property (@(posedge i_clk) disable iff (!i_rstn) !(buf_push0 && buf_full0 && !buf_pop0));
  no_ovf1: assert property (@(posedge i_clk) disable iff (!i_rstn) !(buf_push1 && buf_full1 && !buf_pop1));

endmodule

// File: tb/tb_tcm_rib_arbiter.sv
// Bench for tcm_rib_arbiter: instance 0 is round-robin, instance 1 is fixed
// priority, both OUTST=2, each with its own 1-cycle slave model.
module tb_tcm_rib_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- signals, indexed [dut][master] ----------------
  logic [31:0] m_addr  [2][2];
  logic        m_wrcs  [2][2];
  logic [3:0]  m_mask  [2][2];
  logic [31:0] m_wdata [2][2];
  logic        m_req   [2][2];
  logic        m_rdy   [2][2];
  logic        m_gnt   [2][2];
  logic        m_rsp   [2][2];
  logic [31:0] m_rdata [2][2];
  logic [31:0] s_addr  [2];
  logic        s_wrcs  [2];
  logic [3:0]  s_mask  [2];
  logic [31:0] s_wdata [2];
  logic        s_req   [2];
  logic        s_gnt   [2];
  logic        s_rsp   [2];
  logic [31:0] s_rdata [2];
  logic        s_rdy   [2];
  logic        sl_hold [2];
  logic        inj_rsp [2];

  // Reference data returned by the slave for a given address
  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return {16'hA5A5, a[17:2]};
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic        rsp_q;
    logic [31:0] rdata_q;

    tcm_rib_arbiter #(.ARB_MODE(d == 0 ? 1 : 0), .OUTST(2)) u_dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_m0_addr(m_addr[d][0]), .i_m0_wrcs(m_wrcs[d][0]), .i_m0_mask(m_mask[d][0]),
      .i_m0_wdata(m_wdata[d][0]), .i_m0_req(m_req[d][0]), .o_m0_gnt(m_gnt[d][0]),
      .o_m0_rsp(m_rsp[d][0]), .o_m0_rdata(m_rdata[d][0]), .i_m0_rdy(m_rdy[d][0]),
      .i_m1_addr(m_addr[d][1]), .i_m1_wrcs(m_wrcs[d][1]), .i_m1_mask(m_mask[d][1]),
      .i_m1_wdata(m_wdata[d][1]), .i_m1_req(m_req[d][1]), .o_m1_gnt(m_gnt[d][1]),
      .o_m1_rsp(m_rsp[d][1]), .o_m1_rdata(m_rdata[d][1]), .i_m1_rdy(m_rdy[d][1]),
      .o_s_addr(s_addr[d]), .o_s_wrcs(s_wrcs[d]), .o_s_mask(s_mask[d]),
      .o_s_wdata(s_wdata[d]), .o_s_req(s_req[d]), .i_s_gnt(s_gnt[d]),
      .i_s_rsp(s_rsp[d]), .i_s_rdata(s_rdata[d]), .o_s_rdy(s_rdy[d])
    );

    // 1-cycle slave: answers every accepted request on the next cycle
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rsp_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        rsp_q   <= s_req[d] & s_gnt[d] & ~sl_hold[d];
        rdata_q <= model_rdata(s_addr[d]);
      end
    end
    assign s_rsp[d]   = rsp_q | inj_rsp[d];
    assign s_rdata[d] = inj_rsp[d] ? 32'hDEAD_BEEF : rdata_q;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [4][$];   // expected rdata per (dut*2 + master)
  int          gcyc_q[4][$];   // grant cycle per accepted request
  int          gnt_log[2][$];  // order of grants per dut
  int          n_assert = 0;
  int          n_fail   = 0;
  bit          chk_lat  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops and compares each accepted response
  always @(negedge clk) begin
    int i;
    int g;
    logic [31:0] e;
    if (rstn) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 2; k++) begin
          if (m_rsp[d][k] && m_rdy[d][k]) begin
            i = d * 2 + k;
            if (exp_q[i].size() == 0) begin
              chk($sformatf("unexpected_rsp_d%0d_m%0d", d, k), m_rsp[d][k], 0);
            end else begin
              e = exp_q[i].pop_front();
              chk($sformatf("rsp_data_d%0d_m%0d", d, k), m_rdata[d][k], e);
              if (gcyc_q[i].size() != 0) begin
                g = gcyc_q[i].pop_front();
                if (chk_lat) chk($sformatf("rsp_latency_d%0d_m%0d", d, k), cyc - g, 1);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and hold it until granted; called just after a posedge
  task automatic issue(input int d, input int k, input logic [31:0] a, input logic w,
                       input logic [3:0] mk, input logic [31:0] wd, output int gc);
    bit done;
    done = 1'b0;
    gc   = -1;
    m_addr[d][k]  = a;
    m_wrcs[d][k]  = w;
    m_mask[d][k]  = mk;
    m_wdata[d][k] = wd;
    m_req[d][k]   = 1'b1;
    exp_q[d*2+k].push_back(model_rdata(a));
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      if (m_gnt[d][k]) begin
        done = 1'b1;
        gc   = cyc;
        gnt_log[d].push_back(k);
        gcyc_q[d*2+k].push_back(cyc);
      end
    end
    chk($sformatf("gnt_wait_d%0d_m%0d", d, k), done, 1);
    @(posedge clk);
    #1;
    m_req[d][k] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s_gnt_d%0d_m%0d", tag, d, k), m_gnt[d][k], 0);
        chk($sformatf("%s_rsp_d%0d_m%0d", tag, d, k), m_rsp[d][k], 0);
        chk($sformatf("%s_rdata_d%0d_m%0d", tag, d, k), m_rdata[d][k], 0);
      end
      chk($sformatf("%s_s_req_d%0d", tag, d), s_req[d], 0);
      chk($sformatf("%s_s_addr_d%0d", tag, d), s_addr[d], 0);
      chk($sformatf("%s_s_wdata_d%0d", tag, d), s_wdata[d], 0);
      chk($sformatf("%s_s_mask_d%0d", tag, d), s_mask[d], 0);
      chk($sformatf("%s_s_wrcs_d%0d", tag, d), s_wrcs[d], 0);
      chk($sformatf("%s_s_rdy_d%0d", tag, d), s_rdy[d], 1);
    end
  endtask

  task automatic clear_masters;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        m_addr[d][k] = '0; m_wrcs[d][k] = 1'b0; m_mask[d][k] = '0;
        m_wdata[d][k] = '0; m_req[d][k] = 1'b0;
      end
    end
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int gc_d;
    int cs;
    rstn = 1'b0;
    clear_masters();
    for (int d = 0; d < 2; d++) begin
      m_rdy[d][0] = 1'b1; m_rdy[d][1] = 1'b1;
      s_gnt[d] = 1'b1; sl_hold[d] = 1'b0; inj_rsp[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rstn = 1'b1;
    step();

    // RR contention: grants alternate M0, M1 with 1-cycle responses
    chk_lat = 1'b1;
    fork
      begin int g; for (int n = 0; n < 4; n++) issue(0, 0, 32'(n*4), 1'b0, 4'hF, 32'h0, g); end
      begin int g; for (int n = 0; n < 4; n++) issue(0, 1, 32'(32'h40 + n*4), 1'b0, 4'hF, 32'h0, g); end
    join
    repeat (3) step();
    chk("rr_grant_count", gnt_log[0].size(), 8);
    for (int n = 0; n < 8; n++)
      chk($sformatf("rr_order_%0d", n), (n < gnt_log[0].size()) ? gnt_log[0][n] : 9, n % 2);
    gnt_log[0].delete();

    // Fixed priority: all M0 grants before any M1 grant
    fork
      begin int g; for (int n = 0; n < 4; n++) issue(1, 0, 32'(n*4), 1'b0, 4'hF, 32'h0, g); end
      begin int g; for (int n = 0; n < 4; n++) issue(1, 1, 32'(32'h40 + n*4), 1'b0, 4'hF, 32'h0, g); end
    join
    repeat (3) step();
    chk("fp_grant_count", gnt_log[1].size(), 8);
    for (int n = 0; n < 8; n++)
      chk($sformatf("fp_order_%0d", n), (n < gnt_log[1].size()) ? gnt_log[1][n] : 9, (n < 4) ? 0 : 1);
    gnt_log[1].delete();
    chk_lat = 1'b0;

    // M1 back-pressure: two responses buffered, third grant held off
    m_rdy[0][1] = 1'b0;
    issue(0, 1, 32'h4, 1'b0, 4'hF, 32'h0, gc_d);
    issue(0, 1, 32'h8, 1'b0, 4'hF, 32'h0, gc_d);
    fork
      issue(0, 1, 32'hC, 1'b0, 4'hF, 32'h0, gc_d);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_gnt_blocked", m_gnt[0][1], 0);
          chk("bp_rsp_pending", m_rsp[0][1], 1);
          chk("bp_rdata_head", m_rdata[0][1], 32'hA5A5_0001);
        end
        @(posedge clk);
        #1;
        m_rdy[0][1] = 1'b1;
      end
    join
    repeat (3) step();

    // Slave stall: request held with stable fields, grant in the 4th cycle
    s_gnt[0] = 1'b0;
    cs = cyc;
    fork
      issue(0, 0, 32'h20, 1'b0, 4'hF, 32'h0, gc_d);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_s_req", s_req[0], 1);
          chk("stall_s_addr", s_addr[0], 32'h20);
          chk("stall_s_mask", s_mask[0], 4'hF);
          chk("stall_no_gnt", m_gnt[0][0], 0);
        end
        @(posedge clk);
        #1;
        s_gnt[0] = 1'b1;
      end
    join
    chk("stall_gnt_cycle", gc_d - cs, 3);
    repeat (2) step();

    // Masked write from M1 forwarded intact; response goes to M1 only
    fork
      issue(0, 1, 32'h80, 1'b1, 4'b0011, 32'h1234_5678, gc_d);
      begin
        @(negedge clk);
        chk("wr_s_wrcs", s_wrcs[0], 1);
        chk("wr_s_mask", s_mask[0], 4'b0011);
        chk("wr_s_wdata", s_wdata[0], 32'h1234_5678);
        chk("wr_s_addr", s_addr[0], 32'h80);
        chk("wr_m1_gnt", m_gnt[0][1], 1);
        chk("wr_m0_gnt", m_gnt[0][0], 0);
      end
    join
    repeat (3) step();

    // Reset with two requests outstanding; stale response afterwards dropped
    sl_hold[0] = 1'b1;
    fork
      issue(0, 0, 32'h0, 1'b0, 4'hF, 32'h0, gc_d);
      issue(0, 1, 32'h40, 1'b0, 4'hF, 32'h0, gc_d);
    join
    rstn = 1'b0;
    clear_masters();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      gcyc_q[i].delete();
    end
    gnt_log[0].delete();
    #1;
    chk_idle_outputs("midreset");
    step();
    rstn = 1'b1;
    sl_hold[0] = 1'b0;
    step();
    inj_rsp[0] = 1'b1;
    @(negedge clk);
    chk("stale_m0_rsp", m_rsp[0][0], 0);
    chk("stale_m1_rsp", m_rsp[0][1], 0);
    step();
    inj_rsp[0] = 1'b0;
    step();

    // After reset M0 has priority again and the FIFOs accept new work
    fork
      issue(0, 0, 32'h10, 1'b0, 4'hF, 32'h0, gc_d);
      begin int g; issue(0, 1, 32'h50, 1'b0, 4'hF, 32'h0, g); end
    join
    repeat (3) step();
    chk("post_reset_grants", gnt_log[0].size(), 2);
    chk("post_reset_first", (gnt_log[0].size() > 0) ? gnt_log[0][0] : 9, 0);
    chk("post_reset_second", (gnt_log[0].size() > 1) ? gnt_log[0][1] : 9, 1);

    for (int i = 0; i < 4; i++)
      chk($sformatf("queue_drained_%0d", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
